// File: rtl/cpu_defs.sv
// Shared definitions for the multicycle control unit: datapath widths,
// opcode/ext field values, ALU opcode encoding, condition codes, FSM state
// encoding, PSR bit positions and the instruction-to-aluOp decode helpers.
package cpu_defs;

  localparam int DATAWIDTH  = 16;
  localparam int REGWIDTH   = 4;
  localparam int ALUOPWIDTH = 4;
  localparam int IMMWIDTH   = 8;
  localparam int PSRWIDTH   = 5;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_t;

  // PSR layout {N,Z,F,L,C}
  localparam int PSR_N = 4;
  localparam int PSR_Z = 3;
  localparam int PSR_F = 2;
  localparam int PSR_L = 1;
  localparam int PSR_C = 0;

  // Major opcodes, instr[15:12]
  localparam logic [3:0] OP_REG   = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_SPEC  = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_BCOND = 4'hC;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // ext field, instr[7:4], under OP_SPEC
  localparam logic [3:0] EXT_LOAD  = 4'h0;
  localparam logic [3:0] EXT_STOR  = 4'h4;
  localparam logic [3:0] EXT_JAL   = 4'h8;
  localparam logic [3:0] EXT_JCOND = 4'hC;
  localparam logic [3:0] EXT_SCOND = 4'hD;

  // ext field under OP_REG
  localparam logic [3:0] EXT_AND  = 4'h1;
  localparam logic [3:0] EXT_OR   = 4'h2;
  localparam logic [3:0] EXT_XOR  = 4'h3;
  localparam logic [3:0] EXT_LSH  = 4'h4;
  localparam logic [3:0] EXT_ADD  = 4'h5;
  localparam logic [3:0] EXT_ADDU = 4'h6;
  localparam logic [3:0] EXT_ADDC = 4'h7;
  localparam logic [3:0] EXT_SUB  = 4'h9;
  localparam logic [3:0] EXT_SUBC = 4'hA;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_MOV  = 4'hD;
  localparam logic [3:0] EXT_NOT  = 4'hE;

  // ALU opcodes
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_ADDU = 4'h1;
  localparam logic [3:0] ALU_ADDC = 4'h2;
  localparam logic [3:0] ALU_SUB  = 4'h3;
  localparam logic [3:0] ALU_SUBC = 4'h4;
  localparam logic [3:0] ALU_CMP  = 4'h5;
  localparam logic [3:0] ALU_AND  = 4'h6;
  localparam logic [3:0] ALU_OR   = 4'h7;
  localparam logic [3:0] ALU_XOR  = 4'h8;
  localparam logic [3:0] ALU_MOV  = 4'h9;
  localparam logic [3:0] ALU_LSH  = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;
  localparam logic [3:0] ALU_NOT  = 4'hC;

  // Condition codes
  localparam logic [3:0] CC_EQ = 4'h0;
  localparam logic [3:0] CC_NE = 4'h1;
  localparam logic [3:0] CC_CS = 4'h2;
  localparam logic [3:0] CC_CC = 4'h3;
  localparam logic [3:0] CC_HI = 4'h4;
  localparam logic [3:0] CC_LS = 4'h5;
  localparam logic [3:0] CC_GT = 4'h6;
  localparam logic [3:0] CC_LE = 4'h7;
  localparam logic [3:0] CC_FS = 4'h8;
  localparam logic [3:0] CC_FC = 4'h9;
  localparam logic [3:0] CC_LO = 4'hA;
  localparam logic [3:0] CC_HS = 4'hB;
  localparam logic [3:0] CC_LT = 4'hC;
  localparam logic [3:0] CC_GE = 4'hD;
  localparam logic [3:0] CC_UC = 4'hE;
  localparam logic [3:0] CC_NV = 4'hF;

  function automatic logic is_imm_alu(input logic [3:0] op);
    logic r;
    r = (op == OP_ANDI) || (op == OP_ORI)  || (op == OP_XORI) ||
        (op == OP_ADDI) || (op == OP_SUBI) || (op == OP_CMPI) ||
        (op == OP_MOVI) || (op == OP_LUI);
    return r;
  endfunction

  function automatic logic [3:0] reg_ext_to_aluop(input logic [3:0] ext);
    logic [3:0] r;
    case (ext)
      EXT_AND:  r = ALU_AND;
      EXT_OR:   r = ALU_OR;
      EXT_XOR:  r = ALU_XOR;
      EXT_LSH:  r = ALU_LSH;
      EXT_ADD:  r = ALU_ADD;
      EXT_ADDU: r = ALU_ADDU;
      EXT_ADDC: r = ALU_ADDC;
      EXT_SUB:  r = ALU_SUB;
      EXT_SUBC: r = ALU_SUBC;
      EXT_CMP:  r = ALU_CMP;
      EXT_MOV:  r = ALU_MOV;
      EXT_NOT:  r = ALU_NOT;
      default:  r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] imm_op_to_aluop(input logic [3:0] op);
    logic [3:0] r;
    case (op)
      OP_ANDI: r = ALU_AND;
      OP_ORI:  r = ALU_OR;
      OP_XORI: r = ALU_XOR;
      OP_ADDI: r = ALU_ADD;
      OP_SUBI: r = ALU_SUB;
      OP_CMPI: r = ALU_CMP;
      OP_MOVI: r = ALU_MOV;
      OP_LUI:  r = ALU_LUI;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Condition-code evaluator (combinational).
// Ports: code      - 4-bit condition code
//        psr       - stored PSR {N,Z,F,L,C}
//        cond_true - 1 when the condition holds
module cond_eval
  import cpu_defs::*;
(
  input  logic [3:0]          code,
  input  logic [PSRWIDTH-1:0] psr,
  output logic                cond_true
);

  logic n, z, f, l, c;

  assign n = psr[PSR_N];
  assign z = psr[PSR_Z];
  assign f = psr[PSR_F];
  assign l = psr[PSR_L];
  assign c = psr[PSR_C];

  always_comb begin
    cond_true = 1'b0;
    case (code)
      CC_EQ:   cond_true = z;
      CC_NE:   cond_true = !z;
      CC_CS:   cond_true = c;
      CC_CC:   cond_true = !c;
      CC_HI:   cond_true = l;
      CC_LS:   cond_true = !l;
      CC_GT:   cond_true = n;
      CC_LE:   cond_true = !n;
      CC_FS:   cond_true = f;
      CC_FC:   cond_true = !f;
      CC_LO:   cond_true = !l && !z;
      CC_HS:   cond_true = l || z;
      CC_LT:   cond_true = !n && !z;
      CC_GE:   cond_true = n || z;
      CC_UC:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle control unit: fetches an instruction, decodes it and sequences
// the register/ALU datapath, PC update and data-memory handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | fetch_req high, wait for instr_vld, latch instruction
// DECODE | register field outputs (rSrc/rDst/aluOp/imm/IMM_MUX)
// EXEC   | single-cycle strobes for ALU/branch/jump/Scond; PSR capture
// MEM    | mem_req held until mem_ack; LOAD write-back on ack
//
// Ports: clk/rst_n; instr/instr_vld from ROM; psr from ALU; mem_ack from
// data memory. Outputs: datapath strobes and selects (write, IMM_MUX,
// COND_RSLT, WB_MUX0, WB_MUX, rSrc, rDst, aluOp, imm), PC control
// (pc_inc, pc_br, pc_jmp), memory request (mem_req, mem_we), fetch_req.
module cpu_ctrl
  import cpu_defs::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATAWIDTH-1:0]  instr,
  input  logic                  instr_vld,
  input  logic [PSRWIDTH-1:0]   psr,
  input  logic                  mem_ack,
  output logic                  write,
  output logic                  IMM_MUX,
  output logic                  COND_RSLT,
  output logic                  WB_MUX0,
  output logic [1:0]            WB_MUX,
  output logic [REGWIDTH-1:0]   rSrc,
  output logic [REGWIDTH-1:0]   rDst,
  output logic [ALUOPWIDTH-1:0] aluOp,
  output logic [IMMWIDTH-1:0]   imm,
  output logic                  pc_inc,
  output logic                  pc_br,
  output logic                  pc_jmp,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  fetch_req
);

  state_t state, state_nxt;

  // run_q keeps fetch_req low while in reset and for the first edge after.
  logic                  run_q;
  logic [DATAWIDTH-1:0]  ir;
  logic [PSRWIDTH-1:0]   psr_q;
  logic [REGWIDTH-1:0]   rsrc_q, rdst_q;
  logic [ALUOPWIDTH-1:0] aluop_q;
  logic [IMMWIDTH-1:0]   imm_q;
  logic                  imm_mux_q;

  logic [3:0] op, ext;
  logic       alu_class, is_cmp, is_load, is_stor, is_mem, cond_true;

  assign op  = ir[15:12];
  assign ext = ir[7:4];

  assign alu_class = (op == OP_REG) || is_imm_alu(op);
  assign is_cmp    = ((op == OP_REG) && (ext == EXT_CMP)) || (op == OP_CMPI);
  assign is_load   = (op == OP_SPEC) && (ext == EXT_LOAD);
  assign is_stor   = (op == OP_SPEC) && (ext == EXT_STOR);
  assign is_mem    = is_load || is_stor;

  // Branch, jump and Scond all carry their condition in the rDst field.
  cond_eval u_cond_eval (
    .code      (ir[11:8]),
    .psr       (psr_q),
    .cond_true (cond_true)
  );

  assign rSrc    = rsrc_q;
  assign rDst    = rdst_q;
  assign aluOp   = aluop_q;
  assign imm     = imm_q;
  assign IMM_MUX = imm_mux_q;
  assign WB_MUX0 = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      psr_q     <= '0;
      rsrc_q    <= '0;
      rdst_q    <= '0;
      aluop_q   <= '0;
      imm_q     <= '0;
      imm_mux_q <= 1'b0;
    end else begin
      if ((state == FETCH) && run_q && instr_vld) begin
        ir <= instr;
      end
      if (state == DECODE) begin
        rsrc_q    <= ir[3:0];
        rdst_q    <= ir[11:8];
        imm_q     <= ir[7:0];
        imm_mux_q <= is_imm_alu(op);
        if (op == OP_REG) begin
          aluop_q <= reg_ext_to_aluop(ext);
        end else if (is_imm_alu(op)) begin
          aluop_q <= imm_op_to_aluop(op);
        end else begin
          aluop_q <= ALU_ADD;
        end
      end
      if ((state == EXEC) && alu_class) begin
        psr_q <= psr;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:  if (run_q && instr_vld) state_nxt = DECODE;
      DECODE: state_nxt = EXEC;
      EXEC:   state_nxt = is_mem ? MEM : FETCH;
      MEM:    if (mem_ack) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    write     = 1'b0;
    WB_MUX    = 2'd0;
    COND_RSLT = 1'b0;
    pc_inc    = 1'b0;
    pc_br     = 1'b0;
    pc_jmp    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    fetch_req = 1'b0;
    case (state)
      FETCH: fetch_req = run_q;
      EXEC: begin
        if (alu_class) begin
          write  = !is_cmp;
          WB_MUX = 2'd2;
          pc_inc = 1'b1;
        end else if (op == OP_SPEC) begin
          case (ext)
            EXT_LOAD, EXT_STOR: ;
            EXT_SCOND: begin
              COND_RSLT = cond_true;
              WB_MUX    = 2'd1;
              write     = 1'b1;
              pc_inc    = 1'b1;
            end
            EXT_JAL: begin
              WB_MUX = 2'd0;
              write  = 1'b1;
              pc_jmp = 1'b1;
            end
            EXT_JCOND: begin
              pc_jmp = cond_true;
              pc_inc = !cond_true;
            end
            default: pc_inc = 1'b1;
          endcase
        end else if (op == OP_BCOND) begin
          pc_br  = cond_true;
          pc_inc = !cond_true;
        end else begin
          pc_inc = 1'b1;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = is_stor;
        if (mem_ack) begin
          pc_inc = 1'b1;
          if (is_load) begin
            write  = 1'b1;
            WB_MUX = 2'd3;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] instr = '0;
  logic        instr_vld = 1'b0;
  logic [4:0]  psr = '0;
  logic        mem_ack = 1'b0;
  logic        write, IMM_MUX, COND_RSLT, WB_MUX0;
  logic [1:0]  WB_MUX;
  logic [3:0]  rSrc, rDst, aluOp;
  logic [7:0]  imm;
  logic        pc_inc, pc_br, pc_jmp, mem_req, mem_we, fetch_req;

  cpu_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .instr     (instr),
    .instr_vld (instr_vld),
    .psr       (psr),
    .mem_ack   (mem_ack),
    .write     (write),
    .IMM_MUX   (IMM_MUX),
    .COND_RSLT (COND_RSLT),
    .WB_MUX0   (WB_MUX0),
    .WB_MUX    (WB_MUX),
    .rSrc      (rSrc),
    .rDst      (rDst),
    .aluOp     (aluOp),
    .imm       (imm),
    .pc_inc    (pc_inc),
    .pc_br     (pc_br),
    .pc_jmp    (pc_jmp),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .fetch_req (fetch_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [1:0] wb;
    logic       cr;
    logic       inc;
    logic       br;
    logic       jmp;
    logic       we;
    logic [3:0] aop;
    logic [3:0] rd;
    logic [3:0] rs;
    logic       immx;
    int         cyc;
    int         memc;
  } exp_t;

  exp_t sb[$];
  int tests  = 0;
  int failed = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    assert (obs === req) else begin
      failed++;
      $error("FAIL %s.%s: observed %0h expected %0h", tag, fld, obs, req);
    end
  endtask

  function automatic exp_t mk(input logic wr, input logic [1:0] wb, input logic cr,
                              input logic inc, input logic br, input logic jmp, input logic we,
                              input logic [3:0] aop, input logic [3:0] rd, input logic [3:0] rs,
                              input logic immx, input int cyc, input int memc);
    exp_t e;
    e.wr = wr; e.wb = wb; e.cr = cr; e.inc = inc; e.br = br; e.jmp = jmp; e.we = we;
    e.aop = aop; e.rd = rd; e.rs = rs; e.immx = immx; e.cyc = cyc; e.memc = memc;
    return e;
  endfunction

  task automatic wait_fetch(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      found = fetch_req;
    end
    chk(tag, "fetch_req", {31'd0, found}, 32'd1);
  endtask

  // Issue one instruction, let the DUT run it, and score the strobe cycle.
  task automatic run_instr(input string tag, input logic [15:0] iw, input logic [4:0] psr_val,
                           input int ack_delay, input exp_t e);
    int   cyc, memc;
    logic done, we_seen;
    exp_t x;
    sb.push_back(e);
    psr = psr_val;
    wait_fetch(tag);
    instr = iw;
    instr_vld = 1'b1;
    cyc = 1;
    memc = 0;
    done = 1'b0;
    we_seen = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      instr_vld = 1'b0;
      instr = '0;
      cyc++;
      mem_ack = mem_req && (memc >= ack_delay);
      #1;
      if (mem_req) begin
        memc++;
        we_seen = we_seen | mem_we;
      end
      if (write || pc_inc || pc_br || pc_jmp) done = 1'b1;
    end
    chk(tag, "strobe_seen", {31'd0, done}, 32'd1);
    x = sb.pop_front();
    chk(tag, "write",     {31'd0, write},     {31'd0, x.wr});
    chk(tag, "WB_MUX",    {30'd0, WB_MUX},    {30'd0, x.wb});
    chk(tag, "COND_RSLT", {31'd0, COND_RSLT}, {31'd0, x.cr});
    chk(tag, "pc_inc",    {31'd0, pc_inc},    {31'd0, x.inc});
    chk(tag, "pc_br",     {31'd0, pc_br},     {31'd0, x.br});
    chk(tag, "pc_jmp",    {31'd0, pc_jmp},    {31'd0, x.jmp});
    chk(tag, "mem_we",    {31'd0, we_seen},   {31'd0, x.we});
    chk(tag, "aluOp",     {28'd0, aluOp},     {28'd0, x.aop});
    chk(tag, "rDst",      {28'd0, rDst},      {28'd0, x.rd});
    chk(tag, "rSrc",      {28'd0, rSrc},      {28'd0, x.rs});
    chk(tag, "IMM_MUX",   {31'd0, IMM_MUX},   {31'd0, x.immx});
    chk(tag, "WB_MUX0",   {31'd0, WB_MUX0},   32'd0);
    chk(tag, "cycles",    cyc,                x.cyc);
    chk(tag, "mem_cycles", memc,              x.memc);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk(tag, "pulse_width", {28'd0, write, pc_inc, pc_br, pc_jmp}, 32'd0);
  endtask

  initial begin
    int   memc2, wr_cnt;
    logic fnd;

    #1;
    chk("reset", "outputs",
        {7'd0, write, IMM_MUX, COND_RSLT, WB_MUX0, WB_MUX, pc_inc, pc_br, pc_jmp,
         mem_req, mem_we, fetch_req, aluOp, rDst, rSrc},
        32'd0);
    chk("reset", "imm", {24'd0, imm}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //                        wr wb  cr inc br jmp we aop   rd    rs    immx cyc memc
    run_instr("add",   16'h0352, 5'b00001, 0, mk(1, 2'd2, 0, 1, 0, 0, 0, 4'h0, 4'h3, 4'h2, 0, 3, 0));
    run_instr("cmpi_z", 16'hB105, 5'b01000, 0, mk(0, 2'd2, 0, 1, 0, 0, 0, 4'h5, 4'h1, 4'h5, 1, 3, 0));
    run_instr("beq_t", 16'hC000, 5'b00000, 0, mk(0, 2'd0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0));
    run_instr("cmpi_0", 16'hB105, 5'b00000, 0, mk(0, 2'd2, 0, 1, 0, 0, 0, 4'h5, 4'h1, 4'h5, 1, 3, 0));
    run_instr("beq_f", 16'hC000, 5'b01000, 0, mk(0, 2'd0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0));
    run_instr("load",  16'h4406, 5'b00000, 3, mk(1, 2'd3, 0, 1, 0, 0, 0, 4'h0, 4'h4, 4'h6, 0, 7, 4));
    run_instr("stor",  16'h4246, 5'b00000, 1, mk(0, 2'd0, 0, 1, 0, 0, 1, 4'h0, 4'h2, 4'h6, 0, 5, 2));
    run_instr("add_n", 16'h0352, 5'b10000, 0, mk(1, 2'd2, 0, 1, 0, 0, 0, 4'h0, 4'h3, 4'h2, 0, 3, 0));
    run_instr("sgt_t", 16'h46D7, 5'b00000, 0, mk(1, 2'd1, 1, 1, 0, 0, 0, 4'h0, 4'h6, 4'h7, 0, 3, 0));
    run_instr("add_0", 16'h0352, 5'b00000, 0, mk(1, 2'd2, 0, 1, 0, 0, 0, 4'h0, 4'h3, 4'h2, 0, 3, 0));
    run_instr("sgt_f", 16'h46D7, 5'b10000, 0, mk(1, 2'd1, 0, 1, 0, 0, 0, 4'h0, 4'h6, 4'h7, 0, 3, 0));
    run_instr("blo_t", 16'hCA00, 5'b00000, 0, mk(0, 2'd0, 0, 0, 1, 0, 0, 4'h0, 4'hA, 4'h0, 0, 3, 0));
    run_instr("add_l", 16'h0352, 5'b00010, 0, mk(1, 2'd2, 0, 1, 0, 0, 0, 4'h0, 4'h3, 4'h2, 0, 3, 0));
    run_instr("blo_f", 16'hCA00, 5'b00000, 0, mk(0, 2'd0, 0, 1, 0, 0, 0, 4'h0, 4'hA, 4'h0, 0, 3, 0));
    run_instr("bhs_t", 16'hCB00, 5'b00000, 0, mk(0, 2'd0, 0, 0, 1, 0, 0, 4'h0, 4'hB, 4'h0, 0, 3, 0));
    run_instr("jal",   16'h4385, 5'b00000, 0, mk(1, 2'd0, 0, 0, 0, 1, 0, 4'h0, 4'h3, 4'h5, 0, 3, 0));
    run_instr("juc",   16'h4EC5, 5'b00000, 0, mk(0, 2'd0, 0, 0, 0, 1, 0, 4'h0, 4'hE, 4'h5, 0, 3, 0));
    run_instr("jnv",   16'h4FC5, 5'b00000, 0, mk(0, 2'd0, 0, 1, 0, 0, 0, 4'h0, 4'hF, 4'h5, 0, 3, 0));
    run_instr("undef", 16'h7123, 5'b00000, 0, mk(0, 2'd0, 0, 1, 0, 0, 0, 4'h0, 4'h1, 4'h3, 0, 3, 0));
    run_instr("movi",  16'hD2FF, 5'b00000, 0, mk(1, 2'd2, 0, 1, 0, 0, 0, 4'h9, 4'h2, 4'hF, 1, 3, 0));
    chk("movi", "imm", {24'd0, imm}, 32'h0000_00FF);

    // mem_ack while idle in FETCH must not produce anything
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("stray_ack", "strobes", {27'd0, write, pc_inc, pc_br, pc_jmp, mem_req}, 32'd0);
    chk("stray_ack", "fetch_req", {31'd0, fetch_req}, 32'd1);
    @(negedge clk);
    mem_ack = 1'b0;

    // Leave Z stored so a cleared PSR after reset is observable
    run_instr("cmpi_z2", 16'hB105, 5'b01000, 0, mk(0, 2'd2, 0, 1, 0, 0, 0, 4'h5, 4'h1, 4'h5, 1, 3, 0));

    // Reset while a LOAD waits in MEM
    psr = 5'b00000;
    wait_fetch("rst_mem");
    instr = 16'h4406;
    instr_vld = 1'b1;
    memc2 = 0;
    for (int i = 0; i < 20 && memc2 < 2; i++) begin
      @(negedge clk);
      instr_vld = 1'b0;
      instr = '0;
      mem_ack = 1'b0;
      #1;
      if (mem_req) memc2++;
    end
    chk("rst_mem", "mem_req_before", {31'd0, mem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mem", "mem_req_in_reset", {31'd0, mem_req}, 32'd0);
    chk("rst_mem", "other_in_reset", {27'd0, write, pc_inc, fetch_req, mem_we, rDst[2]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    wr_cnt = 0;
    fnd = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      if (write) wr_cnt++;
      if (fetch_req) fnd = 1'b1;
    end
    mem_ack = 1'b0;
    chk("rst_mem", "writes_after", wr_cnt, 0);
    chk("rst_mem", "fetch_after", {31'd0, fnd}, 32'd1);

    // Stored PSR was cleared by reset, so BEQ falls through
    run_instr("beq_rst", 16'hC000, 5'b01000, 0, mk(0, 2'd0, 0, 1, 0, 0, 0, 4'h0, 4'h0, 4'h0, 0, 3, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
